// File: rtl/morse_encoder_pkg.sv
// Shared types, phase durations and the A-Z Morse table for the letter encoder.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2,
        TAIL = 2'd3
    } state_t;

    localparam logic [1:0] DOT_UNITS  = 2'd1;
    localparam logic [1:0] DASH_UNITS = 2'd3;
    localparam logic [1:0] GAP_UNITS  = 2'd1;
    localparam logic [1:0] TAIL_UNITS = 2'd3;

    localparam logic [4:0] LETTER_MAX = 5'd25;

    // Returns {len[2:0], pattern[3:0]}; pattern is MSB first, 1 = dash, left-aligned.
    function automatic logic [6:0] morse_lookup(input logic [4:0] letter);
        logic [6:0] entry;
        case (letter)
            5'd0:    entry = {3'd2, 4'b0100}; // A .-
            5'd1:    entry = {3'd4, 4'b1000}; // B -...
            5'd2:    entry = {3'd4, 4'b1010}; // C -.-.
            5'd3:    entry = {3'd3, 4'b1000}; // D -..
            5'd4:    entry = {3'd1, 4'b0000}; // E .
            5'd5:    entry = {3'd4, 4'b0010}; // F ..-.
            5'd6:    entry = {3'd3, 4'b1100}; // G --.
            5'd7:    entry = {3'd4, 4'b0000}; // H ....
            5'd8:    entry = {3'd2, 4'b0000}; // I ..
            5'd9:    entry = {3'd4, 4'b0111}; // J .---
            5'd10:   entry = {3'd3, 4'b1010}; // K -.-
            5'd11:   entry = {3'd4, 4'b0100}; // L .-..
            5'd12:   entry = {3'd2, 4'b1100}; // M --
            5'd13:   entry = {3'd2, 4'b1000}; // N -.
            5'd14:   entry = {3'd3, 4'b1110}; // O ---
            5'd15:   entry = {3'd4, 4'b0110}; // P .--.
            5'd16:   entry = {3'd4, 4'b1101}; // Q --.-
            5'd17:   entry = {3'd3, 4'b0100}; // R .-.
            5'd18:   entry = {3'd3, 4'b0000}; // S ...
            5'd19:   entry = {3'd1, 4'b1000}; // T -
            5'd20:   entry = {3'd3, 4'b0010}; // U ..-
            5'd21:   entry = {3'd4, 4'b0001}; // V ...-
            5'd22:   entry = {3'd3, 4'b0110}; // W .--
            5'd23:   entry = {3'd4, 4'b1001}; // X -..-
            5'd24:   entry = {3'd4, 4'b1011}; // Y -.--
            5'd25:   entry = {3'd4, 4'b1100}; // Z --..
            default: entry = 7'd0;
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// Handshake and light-output bundle between a letter source and the encoder.
interface morse_encoder_if;
    logic [4:0] letter;
    logic       start;
    logic       abort;
    logic       z;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output letter, start, abort, input z, busy, done, err);
    modport slave  (input letter, start, abort, output z, busy, done, err);
endinterface

// File: rtl/morse_encoder_unit_timer.sv
// Phase timer: loads units x UNIT_CYCLES, counts down, strobes expire on the last cycle.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [1:0] units_i,
    output logic       expire_o
);
    localparam int W = $clog2(3 * UNIT_CYCLES);
    localparam logic [W-1:0] LD1 = W'(UNIT_CYCLES);
    localparam logic [W-1:0] LD2 = W'(2 * UNIT_CYCLES);
    localparam logic [W-1:0] LD3 = W'(3 * UNIT_CYCLES);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload wins over counting; a load of zero units parks the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            case (units_i)
                2'd1:    cnt_d = LD1;
                2'd2:    cnt_d = LD2;
                2'd3:    cnt_d = LD3;
                default: cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == W'(1));
endmodule

// File: rtl/morse_encoder.sv
// Morse letter transmitter: FSM, symbol shift register and symbol counter.
//   state | meaning
//   IDLE  | waiting for start; z=0, busy=0
//   MARK  | light on for one dot (1 unit) or dash (3 units)
//   GAP   | light off for 1 unit between symbols
//   TAIL  | light off for 3 units after the last symbol, then done
module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25_000_000,
    parameter int MAX_LEN     = 4
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    morse_encoder_if.slave  bus
);
    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   pat_q, pat_d;
    logic [2:0]           len_q, len_d;
    logic                 z_q, busy_q, done_q, err_q;
    logic                 done_d, err_d;
    logic                 tmr_load;
    logic [1:0]           tmr_units;
    logic                 expire;
    logic [6:0]           entry;

    assign entry = morse_lookup(bus.letter);

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk      (CLOCK_50),
        .rst_n    (resetn),
        .load_i   (tmr_load),
        .units_i  (tmr_units),
        .expire_o (expire)
    );

    // Next-state, datapath and timer-reload decisions.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_units = 2'd0;
        case (state_q)
            IDLE: begin
                if (bus.start && !busy_q && !bus.abort) begin
                    if (bus.letter > LETTER_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        len_d     = entry[6:4];
                        pat_d     = entry[MAX_LEN-1:0];
                        state_d   = MARK;
                        tmr_load  = 1'b1;
                        tmr_units = entry[MAX_LEN-1] ? DASH_UNITS : DOT_UNITS;
                    end
                end
            end
            MARK: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    tmr_load = 1'b1;
                end else if (expire) begin
                    pat_d    = pat_q << 1;
                    len_d    = len_q - 3'd1;
                    tmr_load = 1'b1;
                    if (len_q != 3'd1) begin
                        state_d   = GAP;
                        tmr_units = GAP_UNITS;
                    end else begin
                        state_d   = TAIL;
                        tmr_units = TAIL_UNITS;
                    end
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    tmr_load = 1'b1;
                end else if (expire) begin
                    state_d   = MARK;
                    tmr_load  = 1'b1;
                    tmr_units = pat_q[MAX_LEN-1] ? DASH_UNITS : DOT_UNITS;
                end
            end
            TAIL: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    tmr_load = 1'b1;
                end else if (expire) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and outputs; outputs follow the next state so they change with it.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            z_q     <= (state_d == MARK);
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.z    = z_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_morse_encoder.sv
// Self-checking bench for morse_encoder with UNIT_CYCLES=4.
module tb_morse_encoder;
    localparam int U = 4;

    typedef struct {
        logic [4:0] letter;
        string      code;
        bit         exp_err;
    } vec_t;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    seg_t exp_q[$];
    vec_t vecs[$];

    morse_encoder_if bus_if();

    morse_encoder #(.UNIT_CYCLES(U), .MAX_LEN(4)) dut (
        .CLOCK_50 (clk),
        .resetn   (rst_n),
        .bus      (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected light timeline from a dot/dash string: marks, 1-unit gaps, 3-unit tail.
    task automatic push_code(input string code);
        for (int i = 0; i < code.len(); i++) begin
            exp_q.push_back('{1'b1, (code[i] == 8'h2d) ? 3 * U : U});
            if (i < code.len() - 1) exp_q.push_back('{1'b0, U});
        end
        exp_q.push_back('{1'b0, 3 * U});
    endtask

    task automatic pop_cmp(input logic lvl, input int len, input string tag);
        seg_t e;
        if (exp_q.size() == 0) begin
            check({tag, " extra segment"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " seg level"}, int'(lvl), int'(e.lvl));
            check({tag, " seg length"}, len, e.len);
        end
    endtask

    task automatic run_letter(input logic [4:0] l, input string code, input string tag);
        logic cur;
        int   run_len;
        int   busy_bad;
        bit   got_done;
        @(negedge clk);
        bus_if.letter = l;
        bus_if.start  = 1'b1;
        push_code(code);
        @(negedge clk);
        bus_if.start  = 1'b0;
        bus_if.letter = 5'd31;
        cur = 1'b1;
        run_len = 0;
        busy_bad = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus_if.done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                if (bus_if.busy !== 1'b1) busy_bad++;
                if (bus_if.z === cur) begin
                    run_len++;
                end else begin
                    pop_cmp(cur, run_len, tag);
                    cur = bus_if.z;
                    run_len = 1;
                end
            end
        end
        check({tag, " done seen"}, int'(got_done), 1);
        pop_cmp(cur, run_len, tag);
        check({tag, " leftover segments"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, " busy while sending"}, busy_bad, 0);
        check({tag, " busy at done"}, int'(bus_if.busy), 0);
        check({tag, " z at done"}, int'(bus_if.z), 0);
        @(negedge clk);
        check({tag, " done one cycle"}, int'(bus_if.done), 0);
    endtask

    task automatic run_err(input logic [4:0] l, input string tag);
        @(negedge clk);
        bus_if.letter = l;
        bus_if.start  = 1'b1;
        @(negedge clk);
        bus_if.start  = 1'b0;
        check({tag, " err pulse"}, int'(bus_if.err), 1);
        check({tag, " busy stays low"}, int'(bus_if.busy), 0);
        check({tag, " z stays low"}, int'(bus_if.z), 0);
        @(negedge clk);
        check({tag, " err one cycle"}, int'(bus_if.err), 0);
        check({tag, " busy after err"}, int'(bus_if.busy), 0);
    endtask

    initial begin
        logic cur;
        int   run_len;
        int   nruns;
        int   dones;
        int   zhi;
        bit   got_done;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus_if.letter = 5'd0;
        bus_if.start  = 1'b0;
        bus_if.abort  = 1'b0;

        vecs.push_back('{5'd0,  ".-",   1'b0});
        vecs.push_back('{5'd16, "--.-", 1'b0});
        vecs.push_back('{5'd27, "",     1'b1});
        vecs.push_back('{5'd4,  ".",    1'b0});
        vecs.push_back('{5'd14, "---",  1'b0});
        vecs.push_back('{5'd7,  "....", 1'b0});
        vecs.push_back('{5'd25, "--..", 1'b0});
        vecs.push_back('{5'd31, "",     1'b1});
        vecs.push_back('{5'd21, "...-", 1'b0});
        vecs.push_back('{5'd19, "-",    1'b0});

        // Reset values while held.
        #22;
        check("reset z", int'(bus_if.z), 0);
        check("reset busy", int'(bus_if.busy), 0);
        check("reset done", int'(bus_if.done), 0);
        check("reset err", int'(bus_if.err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven letters and invalid codes.
        foreach (vecs[i]) begin
            if (vecs[i].exp_err) run_err(vecs[i].letter, $sformatf("vec%0d", i));
            else                 run_letter(vecs[i].letter, vecs[i].code, $sformatf("vec%0d", i));
        end

        // Async reset in the middle of a dash.
        @(negedge clk);
        bus_if.letter = 5'd19;
        bus_if.start  = 1'b1;
        @(negedge clk);
        bus_if.start  = 1'b0;
        repeat (4) @(negedge clk);
        check("mid-dash z before reset", int'(bus_if.z), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset z", int'(bus_if.z), 0);
        check("async reset busy", int'(bus_if.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle after reset busy", int'(bus_if.busy), 0);
        run_letter(5'd4, ".", "E after reset");

        // Abort during the second mark of A.
        @(negedge clk);
        bus_if.letter = 5'd0;
        bus_if.start  = 1'b1;
        @(negedge clk);
        bus_if.start  = 1'b0;
        repeat (9) @(negedge clk);
        check("abort: in second mark", int'(bus_if.z), 1);
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.abort = 1'b0;
        check("abort z", int'(bus_if.z), 0);
        check("abort busy", int'(bus_if.busy), 0);
        dones = 0;
        zhi = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) dones++;
            if (bus_if.z === 1'b1) zhi++;
        end
        check("abort no done", dones, 0);
        check("abort z stays low", zhi, 0);

        // start and abort together in IDLE.
        @(negedge clk);
        bus_if.letter = 5'd4;
        bus_if.start  = 1'b1;
        bus_if.abort  = 1'b1;
        @(negedge clk);
        bus_if.start  = 1'b0;
        bus_if.abort  = 1'b0;
        check("start+abort busy", int'(bus_if.busy), 0);
        zhi = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus_if.z === 1'b1 || bus_if.busy === 1'b1) zhi++;
        end
        check("start+abort no transmission", zhi, 0);

        // Back-to-back T with start held high.
        @(negedge clk);
        bus_if.letter = 5'd19;
        bus_if.start  = 1'b1;
        exp_q.push_back('{1'b1, 3 * U});
        exp_q.push_back('{1'b0, 3 * U + 1});
        exp_q.push_back('{1'b1, 3 * U});
        @(negedge clk);
        cur = 1'b1;
        run_len = 0;
        nruns = 0;
        dones = 0;
        for (int cyc = 0; cyc < 100 && nruns < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus_if.done === 1'b1) dones++;
            if (bus_if.z === cur) begin
                run_len++;
            end else begin
                pop_cmp(cur, run_len, "b2b");
                nruns++;
                cur = bus_if.z;
                run_len = 1;
            end
        end
        bus_if.start = 1'b0;
        check("b2b runs observed", nruns, 3);
        check("b2b done between letters", dones, 1);
        got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) got_done = 1'b1;
        end
        check("b2b second done", int'(got_done), 1);
        repeat (3) @(negedge clk);
        check("b2b idle after", int'(bus_if.busy), 0);
        exp_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
